// File: rtl/bitmap_bram_writer_pkg.sv
// Shared definitions for the bitmap BRAM writer and the bitmap reader.
package bitmap_bram_writer_pkg;

  // Writer FSM states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Default frame geometry, shared with the readout side.
  localparam int unsigned FRAME_BITS_DEFAULT = 616;
  localparam int unsigned ADDR_W_DEFAULT     = 10;

  // Bit of the shift register that goes out next.
  function automatic logic first_bit(input logic [7:0] b, input logic lsb_first);
    return lsb_first ? b[0] : b[7];
  endfunction

  // Shift register contents once the next bit has gone out.
  function automatic logic [7:0] advance(input logic [7:0] b, input logic lsb_first);
    return lsb_first ? {1'b0, b[7:1]} : {b[6:0], 1'b0};
  endfunction

endpackage

// File: rtl/bitmap_bram_writer.sv
// Unpacks a byte stream into single-bit BRAM writes at ascending addresses,
// filling one FRAME_BITS-bit frame per start command. All outputs registered.
module bitmap_bram_writer
  import bitmap_bram_writer_pkg::*;
#(
  parameter int unsigned ADDR_W     = ADDR_W_DEFAULT,
  parameter int unsigned FRAME_BITS = FRAME_BITS_DEFAULT,
  parameter int unsigned LSB_FIRST  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_din,
  output logic              mem_we,
  output logic              busy,
  output logic              frame_done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_BITS - 1);
  localparam logic              LSB       = (LSB_FIRST != 0);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        shift_q, shift_d;
  logic              in_ready_q, in_ready_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              din_q, din_d;
  logic              we_q, we_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              transfer;
  logic [ADDR_W-1:0] wr_ptr_inc;

  assign transfer   = in_valid & in_ready_q;
  // The pointer saturates on the last frame address instead of wrapping.
  assign wr_ptr_inc = (wr_ptr_q == LAST_ADDR) ? wr_ptr_q : wr_ptr_q + ADDR_W'(1);

  // State register and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      in_ready_q <= 1'b0;
      addr_q     <= '0;
      din_q      <= 1'b0;
      we_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      in_ready_q <= in_ready_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
      we_q       <= we_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Next-state and next-output logic. The output registers describe the cycle
  // after the decision, so the first bit of a byte is issued at the accepting
  // edge and in_ready is raised one bit early to land on the byte's last bit.
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    in_ready_d = 1'b0;
    addr_d     = addr_q;
    din_d      = din_q;
    we_d       = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;

    if (start) begin
      state_d    = ST_WAIT;
      wr_ptr_d   = '0;
      bit_cnt_d  = '0;
      shift_d    = '0;
      in_ready_d = 1'b1;
      busy_d     = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          busy_d = 1'b0;
        end
        ST_WAIT: begin
          if (transfer) begin
            state_d   = ST_SHIFT;
            bit_cnt_d = '0;
            we_d      = 1'b1;
            addr_d    = wr_ptr_q;
            din_d     = first_bit(in_data, LSB);
            shift_d   = advance(in_data, LSB);
            wr_ptr_d  = wr_ptr_inc;
          end else begin
            in_ready_d = 1'b1;
          end
        end
        ST_SHIFT: begin
          if (addr_q == LAST_ADDR) begin
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else if (bit_cnt_q == 3'd7) begin
            if (transfer) begin
              bit_cnt_d = '0;
              we_d      = 1'b1;
              addr_d    = wr_ptr_q;
              din_d     = first_bit(in_data, LSB);
              shift_d   = advance(in_data, LSB);
              wr_ptr_d  = wr_ptr_inc;
            end else begin
              state_d    = ST_WAIT;
              in_ready_d = 1'b1;
            end
          end else begin
            bit_cnt_d  = bit_cnt_q + 3'd1;
            we_d       = 1'b1;
            addr_d     = wr_ptr_q;
            din_d      = first_bit(shift_q, LSB);
            shift_d    = advance(shift_q, LSB);
            wr_ptr_d   = wr_ptr_inc;
            in_ready_d = (bit_cnt_q == 3'd6) && (wr_ptr_q != LAST_ADDR);
          end
        end
        default: begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign mem_addr   = addr_q;
  assign mem_din    = din_q;
  assign mem_we     = we_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule
